// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: writes one RGB565 colour into a framebuffer rectangle, one SDRAM word per access.
// Optional FB_RECT_FILL_CLIP_EN clips the rectangle to the FB_WIDTH x FB_HEIGHT frame.
module fb_rect_fill #(
  parameter int FB_WIDTH  = 640,
  parameter int FB_HEIGHT = 480,
  parameter int ADDR_W    = 22,
  parameter int GUARD     = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [9:0]        x0,
  input  logic [9:0]        y0,
  input  logic [9:0]        w,
  input  logic [9:0]        h,
  input  logic [15:0]       color,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] address,
  output logic [15:0]       o_data,
  output logic              rdwr,
  output logic              clk,
  input  logic              lock
);

  localparam int GW = $clog2(GUARD + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_ISSUE, ST_GUARD, ST_WAITLK, ST_NEXT, ST_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_l, row_addr, y_off, start_addr;
  logic [9:0]        x0_l, y0_l, w_l, h_l, eff_w, eff_h;
  logic [15:0]       color_l;
  logic [9:0]        col, row;
  logic [10:0]       col_inc, row_inc;
  logic              col_last, row_last;
  logic [GW-1:0]     gcnt;

  assign rdwr = 1'b1;

  // Effective rectangle size; without clipping the request is taken as given.
  always_comb begin
    eff_w = w_l;
    eff_h = h_l;
`ifdef FB_RECT_FILL_CLIP_EN
    if (int'(x0_l) >= FB_WIDTH)
      eff_w = '0;
    else if (int'(w_l) > FB_WIDTH - int'(x0_l))
      eff_w = 10'(FB_WIDTH - int'(x0_l));
    if (int'(y0_l) >= FB_HEIGHT)
      eff_h = '0;
    else if (int'(h_l) > FB_HEIGHT - int'(y0_l))
      eff_h = 10'(FB_HEIGHT - int'(y0_l));
`endif
  end

  assign y_off      = ADDR_W'(y0_l) * ADDR_W'(FB_WIDTH);
  assign start_addr = base_l + y_off + ADDR_W'(x0_l);
  assign col_inc    = {1'b0, col} + 11'd1;
  assign row_inc    = {1'b0, row} + 11'd1;
  assign col_last   = col_inc >= {1'b0, eff_w};
  assign row_last   = row_inc >= {1'b0, eff_h};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // clk is decoded straight from state and lock so it can never coincide with lock=1
  // and collapses the instant reset_n falls.
  always_comb begin
    state_nxt = state;
    clk       = 1'b0;
    done      = 1'b0;
    busy      = (state != ST_IDLE) && (state != ST_DONE);
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = (eff_w == '0 || eff_h == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: begin
        if (!lock) begin
          clk       = 1'b1;
          state_nxt = ST_GUARD;
        end
      end
      ST_GUARD:  if (gcnt == GW'(GUARD - 1)) state_nxt = ST_WAITLK;
      ST_WAITLK: if (!lock) state_nxt = ST_NEXT;
      ST_NEXT:   state_nxt = (col_last && row_last) ? ST_DONE : ST_ISSUE;
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Pixel walk: address/o_data only change in SETUP and NEXT, so they hold through an access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col     <= '0;
      row     <= '0;
      gcnt    <= '0;
      address <= '0;
      o_data  <= '0;
    end else begin
      case (state)
        ST_SETUP: begin
          col     <= '0;
          row     <= '0;
          address <= start_addr;
          o_data  <= color_l;
        end
        ST_ISSUE: gcnt <= '0;
        ST_GUARD: gcnt <= gcnt + GW'(1);
        ST_NEXT: begin
          if (!col_last) begin
            col     <= col_inc[9:0];
            address <= row_addr + ADDR_W'(col_inc[9:0]);
          end else if (!row_last) begin
            col     <= '0;
            row     <= row_inc[9:0];
            address <= row_addr + ADDR_W'(FB_WIDTH);
          end
        end
        default: ;
      endcase
    end
  end

  // Request latch and line base; no reset needed, always written before use.
  always_ff @(posedge clock) begin
    if (state == ST_IDLE && start) begin
      base_l  <= base;
      x0_l    <= x0;
      y0_l    <= y0;
      w_l     <= w;
      h_l     <= h;
      color_l <= color;
    end
    if (state == ST_SETUP)
      row_addr <= start_addr;
    else if (state == ST_NEXT && col_last && !row_last)
      row_addr <= row_addr + ADDR_W'(FB_WIDTH);
  end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill: scoreboard of expected writes checked against observed strobes.
module tb_fb_rect_fill;
  localparam int AW  = 22;
  localparam int FBW = 640;
  localparam int FBH = 480;

  logic          clock = 1'b0, reset_n = 1'b0, start = 1'b0, lock = 1'b0;
  logic [AW-1:0] base = '0;
  logic [9:0]    x0 = '0, y0 = '0, w = '0, h = '0;
  logic [15:0]   color = '0;
  logic          busy, done, rdwr, clk;
  logic [AW-1:0] address;
  logic [15:0]   o_data;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0;
  int strobes = 0, dones = 0, cyc = 0, last_strobe = -100;
  bit hold_lock = 1'b0;
  int lock_cnt = 0;

  fb_rect_fill dut (
    .clock(clock), .reset_n(reset_n), .start(start), .base(base),
    .x0(x0), .y0(y0), .w(w), .h(h), .color(color),
    .busy(busy), .done(done), .address(address), .o_data(o_data),
    .rdwr(rdwr), .clk(clk), .lock(lock)
  );

  initial forever #5 clock = ~clock;
  initial forever begin @(posedge clock); cyc++; end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_fill(input logic [AW-1:0] b, input int x, input int y,
                           input int ww, input int hh, input logic [15:0] c);
    int   ew, eh;
    exp_t e;
    ew = ww;
    eh = hh;
`ifdef FB_RECT_FILL_CLIP_EN
    ew = (x >= FBW) ? 0 : ((ww < FBW - x) ? ww : FBW - x);
    eh = (y >= FBH) ? 0 : ((hh < FBH - y) ? hh : FBH - y);
`endif
    for (int r = 0; r < eh; r++)
      for (int cc = 0; cc < ew; cc++) begin
        e.a = b + AW'((y + r) * FBW + x + cc);
        e.d = c;
        exp_q.push_back(e);
      end
  endtask

  task automatic start_fill(input logic [AW-1:0] b, input int x, input int y,
                            input int ww, input int hh, input logic [15:0] c);
    @(posedge clock); #1;
    base = b; x0 = 10'(x); y0 = 10'(y); w = 10'(ww); h = 10'(hh); color = c;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
  endtask

  task automatic wait_done(input string tag, input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clock); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(lat > 0), 1);
    if (lat > 0) begin
      check({tag, "_busy_low_with_done"}, 32'(busy), 0);
      @(negedge clock); #1;
      check({tag, "_done_single"}, 32'(done), 0);
    end
  endtask

  // Controller model: lock rises the cycle after a strobe and stays high 7 cycles.
  initial begin
    bit seen;
    forever begin
      @(negedge clock);
      seen = clk;
      @(posedge clock); #1;
      if (seen) lock_cnt = 7;
      if (hold_lock) lock = 1'b1;
      else if (lock_cnt > 0) begin
        lock = 1'b1;
        lock_cnt--;
      end else lock = 1'b0;
    end
  end

  // Strobe monitor / scoreboard consumer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (done) dones++;
      if (clk) begin
        strobes++;
        check("strobe_lock_low", 32'(lock), 0);
        check("strobe_gap", 32'(cyc - last_strobe >= 3), 1);
        check("strobe_rdwr", 32'(rdwr), 1);
        last_strobe = cyc;
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_strobe: observed address %0d, expected no strobe", address);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("strobe_addr", 32'(address), 32'(e.a));
          check("strobe_data", 32'(o_data), 32'(e.d));
        end
      end
    end
  end

  initial begin
    int lat, s0, d0, bad, n_exp;
    logic [AW-1:0] hold_addr;

    #2;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_clk", 32'(clk), 0);
    check("rst_address", 32'(address), 0);
    check("rst_o_data", 32'(o_data), 0);
    check("rst_rdwr", 32'(rdwr), 1);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Basic 3x2 fill
    push_fill(0, 10, 5, 3, 2, 16'hF800);
    s0 = strobes; d0 = dones;
    start_fill(0, 10, 5, 3, 2, 16'hF800);
    wait_done("basic", 500, lat);
    check("basic_strobes", strobes - s0, 6);
    check("basic_queue_empty", exp_q.size(), 0);
    check("basic_done_pulses", dones - d0, 1);
    repeat (10) @(posedge clock);

    // Zero width
    s0 = strobes;
    start_fill(0, 3, 3, 0, 5, 16'h1111);
    wait_done("zero_w", 3, lat);
    check("zero_w_latency", lat, 2);
    check("zero_w_strobes", strobes - s0, 0);

    // Lock held off for 200 cycles
    hold_lock = 1'b1;
    repeat (2) @(posedge clock);
    push_fill(100, 4, 2, 2, 1, 16'h07E0);
    s0 = strobes;
    start_fill(100, 4, 2, 2, 1, 16'h07E0);
    @(posedge clock); #1;
    hold_addr = AW'(100 + 2 * FBW + 4);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock); #1;
      if (clk !== 1'b0 || address !== hold_addr) bad++;
    end
    check("hold_stable_no_strobe", bad, 0);
    check("hold_strobes", strobes - s0, 0);
    hold_lock = 1'b0;
    repeat (2) @(negedge clock);
    #1 check("hold_release_strobe", strobes - s0, 1);
    wait_done("hold", 200, lat);
    check("hold_queue_empty", exp_q.size(), 0);
    repeat (10) @(posedge clock);

    // Clip corner
    n_exp = exp_q.size();
    push_fill(0, 638, 479, 5, 3, 16'h001F);
    n_exp = exp_q.size() - n_exp;
    s0 = strobes;
    start_fill(0, 638, 479, 5, 3, 16'h001F);
    wait_done("clip", 1000, lat);
`ifdef FB_RECT_FILL_CLIP_EN
    check("clip_expected_count", n_exp, 2);
`else
    check("clip_expected_count", n_exp, 15);
`endif
    check("clip_strobes", strobes - s0, n_exp);
    check("clip_queue_empty", exp_q.size(), 0);
    repeat (10) @(posedge clock);

    // Reset after third strobe of a 4x4 fill
    push_fill(2000, 0, 0, 4, 4, 16'hC0DE);
    s0 = strobes; d0 = dones;
    start_fill(2000, 0, 0, 4, 4, 16'hC0DE);
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock); #1;
      if (strobes - s0 >= 3) begin
        lat = i;
        break;
      end
    end
    check("rst_mid_third_strobe", 32'(lat >= 0), 1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_clk", 32'(clk), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_done", 32'(done), 0);
    exp_q.delete();
    @(posedge clock); #1 reset_n = 1'b1;
    repeat (60) @(negedge clock);
    #1;
    check("rst_mid_no_more_strobes", strobes - s0, 3);
    check("rst_mid_no_done", dones - d0, 0);
    check("rst_mid_idle", 32'(busy), 0);

    // Start while busy is ignored
    push_fill(1000, 0, 0, 3, 1, 16'h1234);
    s0 = strobes; d0 = dones;
    start_fill(1000, 0, 0, 3, 1, 16'h1234);
    repeat (4) @(posedge clock);
    #1;
    base = 5000; x0 = 10'd50; y0 = 10'd7; w = 10'd9; h = 10'd4; color = 16'hABCD;
    start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    wait_done("busy_start", 300, lat);
    repeat (20) @(negedge clock);
    #1;
    check("busy_start_strobes", strobes - s0, 3);
    check("busy_start_queue_empty", exp_q.size(), 0);
    check("busy_start_done_pulses", dones - d0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
